// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI responder in front of a word-organised 32-bit SRAM model.
// Handles single-beat and burst reads and writes (INCR and FIXED; WRAP is
// stepped like INCR). There is one outstanding read and one outstanding write,
// and the read and write channels run independently of each other.
//
// Ports:
//   aclk, areset        clock; synchronous active-high reset
//   ar*/arready         read address channel
//   r*/rready           read data channel (rresp is always OKAY)
//   aw*/awready         write address channel
//   w*/wready           write data channel (wid is ignored)
//   b*/bready           write response channel (SLVERR on a wlast/len mismatch)
//
// Optional build macro AXI_SLV_STALL_EN: a 16-bit LFSR randomly withholds
// arready, awready and wready, and delays the raising of rvalid. This
// exercises back-pressure in the master.
module axi_sram_slave #(
  parameter int ADDR_W = 12,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic { R_IDLE, R_DATA } r_state_t;
  typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  // go=0 withholds the ready signals and the raising of a new rvalid.
  logic go;
`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge aclk) begin
    if (areset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign go = lfsr[0];
`else
  assign go = 1'b1;
`endif

  logic unused_wid;
  assign unused_wid = ^wid;

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [31:0] r_addr, r_data;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_shown;
  logic        r_last, ar_hs, r_hs;

  assign r_last  = (r_cnt == r_len);
  assign arready = !areset && (r_state == R_IDLE) && go;
  // r_shown keeps rvalid up once it has been presented, regardless of stalls.
  assign rvalid  = !areset && (r_state == R_DATA) && (r_shown || go);
  assign rlast   = !areset && (r_state == R_DATA) && r_last;
  assign rid     = areset ? '0 : r_id;
  assign rdata   = areset ? '0 : r_data;
  assign rresp   = 2'b00;

  always_comb begin
    r_next = r_state;
    ar_hs  = 1'b0;
    r_hs   = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid && arready) begin
        ar_hs  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (rvalid && rready) begin
        r_hs = 1'b1;
        if (r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_shown <= 1'b0;
    end else begin
      r_state <= r_next;
      r_shown <= rvalid && !rready;
    end
  end

  // Reads see the memory before any same-cycle write lands.
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= 8'd0;
      r_data  <= mem[word_idx(araddr)];
    end else if (r_hs && !r_last) begin
      r_addr <= next_addr(r_addr, r_size, r_burst);
      r_cnt  <= r_cnt + 8'd1;
      r_data <= mem[word_idx(next_addr(r_addr, r_size, r_burst))];
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err, aw_hs, w_hs, w_end;

  assign awready = !areset && (w_state == W_IDLE) && go;
  assign wready  = !areset && (w_state == W_DATA) && go;
  assign bvalid  = !areset && (w_state == W_RESP);
  assign bid     = areset ? '0 : w_id;
  assign bresp   = (!areset && w_err) ? 2'b10 : 2'b00;
  // The burst ends at the declared length or at an early wlast.
  assign w_end   = (w_cnt == w_len) || wlast;

  always_comb begin
    w_next = w_state;
    aw_hs  = 1'b0;
    w_hs   = 1'b0;
    case (w_state)
      W_IDLE: if (awvalid && awready) begin
        aw_hs  = 1'b1;
        w_next = W_DATA;
      end
      W_DATA: if (wvalid && wready) begin
        w_hs = 1'b1;
        if (w_end) w_next = W_RESP;
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= 8'd0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err | (wlast != (w_cnt == w_len));
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus tasks push the expected R
// beats and B responses, and a negedge monitor pops and compares them.
module tb_axi_sram_slave;
  localparam int ADDR_W = 12;
  localparam int ID_W   = 4;

  logic aclk, areset;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] data; logic [ID_W-1:0] id; logic last; } r_exp_t;
  typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  int n_vec = 0;
  int n_miss = 0;
  logic rr_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // ---------------- monitor ----------------
  r_exp_t me;
  b_exp_t mb;
  logic held = 1'b0;
  logic [31:0] h_data;
  logic [ID_W-1:0] h_id;
  logic h_last;

  always @(negedge aclk) begin
    if (areset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, h_data);
        chk("r_hold_id", 32'(rid), 32'(h_id));
        chk("r_hold_last", 32'(rlast), 32'(h_last));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL r_unexpected: got beat %h, expected no beat", rdata);
        end else begin
          me = exp_r.pop_front();
          chk("rdata", rdata, me.data);
          chk("rid", 32'(rid), 32'(me.id));
          chk("rlast", 32'(rlast), 32'(me.last));
          chk("rresp", 32'(rresp), 32'd0);
        end
      end
      held   = rvalid && !rready;
      h_data = rdata;
      h_id   = rid;
      h_last = rlast;
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL b_unexpected: got bresp %b, expected no response", bresp);
        end else begin
          mb = exp_b.pop_front();
          chk("bid", 32'(bid), 32'(mb.id));
          chk("bresp", 32'(bresp), 32'(mb.resp));
        end
      end
    end
  end

  // rready: held high, or toggling every cycle when rr_toggle is set.
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1 rready = rr_toggle ? ~rready : 1'b1;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic push_r(input logic [31:0] d, input logic [ID_W-1:0] id, input logic last);
    r_exp_t e;
    e.data = d; e.id = id; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    bit ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      ok = arready;
      @(posedge aclk);
    end
    #1 arvalid = 1'b0;
    if (!ok) fail_now("ar_handshake");
    else chk("r_first_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      ok = awready;
      @(posedge aclk);
    end
    #1 awvalid = 1'b0;
    if (!ok) fail_now("aw_handshake");
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    bit ok = 1'b0;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      ok = wready;
      @(posedge aclk);
    end
    #1 wvalid = 1'b0;
    wlast = 1'b0;
    if (!ok) fail_now("w_handshake");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (exp_r.size() != 0 || exp_b.size() != 0); i++)
      @(posedge aclk);
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      fail_now("drain");
      exp_r.delete();
      exp_b.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  // Writes nbeats beats of d (beat b in d[32b+31:32b]) with wlast on beat last_at.
  task automatic write_burst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [127:0] d, input logic [3:0] strb,
                             input int nbeats, input int last_at, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
    do_aw(id, addr, len);
    for (int b = 0; b < nbeats; b++) do_w(d[32*b +: 32], strb, b == last_at);
    wait_drain();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_wready_before_aw", 32'(wready), 32'd0);
    @(posedge aclk);
    #1;

    // single-beat write then read of word 4
    write_burst(4'd0, 32'h10, 8'd0, 128'h1111_2222, 4'hF, 1, 0, 2'b00);
    push_r(32'h1111_2222, 4'd1, 1'b1);
    do_ar(4'd1, 32'h10, 8'd0, 2'b01);
    wait_drain();

    // words 8..11 = A0..A3, INCR read with rready high, then toggling
    write_burst(4'd2, 32'h20, 8'd3, {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000},
                4'hF, 4, 3, 2'b00);
    push_r(32'hA000_0000, 4'd0, 1'b0); push_r(32'hA111_1111, 4'd0, 1'b0);
    push_r(32'hA222_2222, 4'd0, 1'b0); push_r(32'hA333_3333, 4'd0, 1'b1);
    do_ar(4'd0, 32'h20, 8'd3, 2'b01);
    wait_drain();
    rr_toggle = 1'b1;
    push_r(32'hA000_0000, 4'd3, 1'b0); push_r(32'hA111_1111, 4'd3, 1'b0);
    push_r(32'hA222_2222, 4'd3, 1'b0); push_r(32'hA333_3333, 4'd3, 1'b1);
    do_ar(4'd3, 32'h20, 8'd3, 2'b01);
    wait_drain();
    rr_toggle = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // 4-beat write at 0x40 with id 1, then readback of words 16..19
    write_burst(4'd1, 32'h40, 8'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 4, 3, 2'b00);
    push_r(32'd1, 4'd6, 1'b0); push_r(32'd2, 4'd6, 1'b0);
    push_r(32'd3, 4'd6, 1'b0); push_r(32'd4, 4'd6, 1'b1);
    do_ar(4'd6, 32'h40, 8'd3, 2'b01);
    wait_drain();

    // byte strobes on word 5
    write_burst(4'd0, 32'h14, 8'd0, 128'hFFFF_FFFF, 4'hF, 1, 0, 2'b00);
    write_burst(4'd0, 32'h14, 8'd0, 128'h1234_5678, 4'b0101, 1, 0, 2'b00);
    push_r(32'hFF34_FF78, 4'd7, 1'b1);
    do_ar(4'd7, 32'h14, 8'd0, 2'b01);
    wait_drain();

    // early wlast: words 32..35 preset to C0..C3, burst stops after 2 beats
    write_burst(4'd0, 32'h80, 8'd3, {32'hC333_3333, 32'hC222_2222, 32'hC111_1111, 32'hC000_0000},
                4'hF, 4, 3, 2'b00);
    write_burst(4'd9, 32'h80, 8'd3, {64'd0, 32'hD111_1111, 32'hD000_0000}, 4'hF, 2, 1, 2'b10);
    push_r(32'hD000_0000, 4'd8, 1'b0); push_r(32'hD111_1111, 4'd8, 1'b0);
    push_r(32'hC222_2222, 4'd8, 1'b0); push_r(32'hC333_3333, 4'd8, 1'b1);
    do_ar(4'd8, 32'h80, 8'd3, 2'b01);
    wait_drain();

    // FIXED burst repeats the same word
    push_r(32'h1111_2222, 4'd5, 1'b0); push_r(32'h1111_2222, 4'd5, 1'b1);
    do_ar(4'd5, 32'h10, 8'd1, 2'b00);
    wait_drain();

    // reset during beat 2 of a 4-beat read
    push_r(32'hA000_0000, 4'd2, 1'b0);
    do_ar(4'd2, 32'h20, 8'd3, 2'b01);
    @(posedge aclk);
    #1 areset = 1'b1;
    @(negedge aclk);
    chk("rstmid_rvalid", 32'(rvalid), 32'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rstmid_rvalid_after", 32'(rvalid), 32'd0);
    chk("rstmid_arready", 32'(arready), 32'd1);
    @(posedge aclk);
    #1;
    wait_drain();
    push_r(32'hA111_1111, 4'd4, 1'b1);
    do_ar(4'd4, 32'h24, 8'd0, 2'b01);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
